// File: rtl/decode_2_4_seq.sv
// Streaming 2-to-4 decoder: codes are decoded on push into a 2-entry FIFO of
// one-hot words, drained over a valid/ready stream, with a saturating pop counter.
module decode_2_4_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       in_code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       out_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] dec_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0]       mem_q [2];
    logic [3:0]       mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
    logic             push, pop;

    function automatic logic [3:0] decode_code(input logic [1:0] code);
        logic [3:0] onehot;
        case (code)
            2'b11:   onehot = 4'b0001;
            2'b10:   onehot = 4'b0010;
            2'b01:   onehot = 4'b0100;
            default: onehot = 4'b1000;
        endcase
        return onehot;
    endfunction

    // Handshake flags come only from registered state, so in_ready never sees out_ready.
    assign in_ready   = (count_q != 2'd2);
    assign out_valid  = (count_q != 2'd0);
    assign out_onehot = out_valid ? mem_q[rd_ptr_q] : 4'b0000;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign dec_cnt    = dec_cnt_q;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dec_cnt_d = dec_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = decode_code(in_code);
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // A clear wins over a coincident pop; that pop goes uncounted.
        if (cnt_clr) begin
            dec_cnt_d = '0;
        end else if (pop && (dec_cnt_q != CNT_MAX)) begin
            dec_cnt_d = dec_cnt_q + CNT_W'(1);
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            dec_cnt_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            dec_cnt_q <= dec_cnt_d;
        end
    end

endmodule

// File: tb/tb_decode_2_4_seq.sv
// Bench for decode_2_4_seq: directed scenarios plus a random stall soak, all checked
// against a queue-based reference model; a CNT_W=2 instance covers counter saturation.
module tb_decode_2_4_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] in_code = 2'b00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       in_ready, out_valid;
    logic [3:0] out_onehot;
    logic [7:0] dec_cnt;
    logic       in_ready_s, out_valid_s;
    logic [3:0] out_onehot_s;
    logic [1:0] dec_cnt_s;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of decoded words and two saturating counters.
    logic [3:0] mq[$];
    int         m_cnt8 = 0;
    int         m_cnt2 = 0;

    decode_2_4_seq #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
        .in_ready(in_ready), .out_onehot(out_onehot), .out_valid(out_valid),
        .out_ready(out_ready), .cnt_clr(cnt_clr), .dec_cnt(dec_cnt)
    );

    decode_2_4_seq #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
        .in_ready(in_ready_s), .out_onehot(out_onehot_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .cnt_clr(cnt_clr), .dec_cnt(dec_cnt_s)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic       m_ready();  return mq.size() != 2; endfunction
    function automatic logic       m_valid();  return mq.size() != 0; endfunction
    function automatic logic [3:0] m_head();   return (mq.size() != 0) ? mq[0] : 4'b0000; endfunction

    function automatic void m_reset();
        mq.delete();
        m_cnt8 = 0;
        m_cnt2 = 0;
    endfunction

    // Drive one cycle's inputs at the falling edge, advance the model over the
    // next rising edge, and return at the following falling edge.
    task automatic step(input logic [1:0] c, input logic v, input logic r, input logic clr);
        bit do_push, do_pop;
        in_code   = c;
        in_valid  = v;
        out_ready = r;
        cnt_clr   = clr;
        do_push   = v && (mq.size() != 2);
        do_pop    = r && (mq.size() != 0);
        @(posedge clk);
        if (clr) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (do_pop) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3)   m_cnt2++;
        end
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back(4'b1000 >> c);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_onehot !== 4'b0000 || in_ready !== 1'b1 || dec_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_init: got v=%b oh=%b rdy=%b cnt=%0d want v=0 oh=0000 rdy=1 cnt=0",
                     out_valid, out_onehot, in_ready, dec_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();

        // One completed transfer, then two words queued behind backpressure.
        step(2'b10, 1'b1, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b1, 1'b0);
        step(2'b11, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (in_ready !== 1'b0 || dec_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_prefill: got rdy=%b cnt=%0d want rdy=0 cnt=1", in_ready, dec_cnt);
        end

        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_onehot !== 4'b0000 || in_ready !== 1'b1 || dec_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_async: got v=%b oh=%b rdy=%b cnt=%0d want v=0 oh=0000 rdy=1 cnt=0",
                     out_valid, out_onehot, in_ready, dec_cnt);
        end
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b01, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || out_onehot !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_first_push: got v=%b oh=%b want v=1 oh=0100", out_valid, out_onehot);
        end
        step(2'b00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_map_sweep();
        logic [1:0] codes [4];
        logic [3:0] want  [4];
        codes[0] = 2'b11; want[0] = 4'b0001;
        codes[1] = 2'b10; want[1] = 4'b0010;
        codes[2] = 2'b01; want[2] = 4'b0100;
        codes[3] = 2'b00; want[3] = 4'b1000;
        step(2'b00, 1'b0, 1'b1, 1'b1);
        n_tests++;
        if (dec_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL map_clear: got cnt=%0d want 0", dec_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            step(codes[i], 1'b1, 1'b1, 1'b0);
            n_tests++;
            if (out_valid !== 1'b1 || out_onehot !== want[i]) begin
                n_fail++;
                $display("FAIL map_out%0d: got v=%b oh=%b want v=1 oh=%b", i, out_valid, out_onehot, want[i]);
            end
        end
        step(2'b00, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (dec_cnt !== 8'd4 || out_valid !== 1'b0 || out_onehot !== 4'b0000) begin
            n_fail++;
            $display("FAIL map_done: got cnt=%0d v=%b oh=%b want cnt=4 v=0 oh=0000", dec_cnt, out_valid, out_onehot);
        end
    endtask

    task automatic test_backpressure();
        step(2'b11, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (in_ready !== 1'b1 || out_onehot !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_first: got rdy=%b oh=%b want rdy=1 oh=0001", in_ready, out_onehot);
        end
        step(2'b00, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: got rdy=%b want 0", in_ready);
        end
        step(2'b10, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_onehot !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_hold: got rdy=%b v=%b oh=%b want rdy=0 v=1 oh=0001", in_ready, out_valid, out_onehot);
        end
        step(2'b00, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (in_ready !== 1'b1 || out_onehot !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_pop1: got rdy=%b oh=%b want rdy=1 oh=1000", in_ready, out_onehot);
        end
        step(2'b00, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b0 || out_onehot !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_drained: got v=%b oh=%b want v=0 oh=0000 (third code leaked?)", out_valid, out_onehot);
        end
    endtask

    task automatic test_simul_push_pop();
        step(2'b10, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_onehot !== 4'b0100) begin
            n_fail++;
            $display("FAIL simul_head: got v=%b rdy=%b oh=%b want v=1 rdy=1 oh=0100", out_valid, in_ready, out_onehot);
        end
        step(2'b00, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_count: got v=%b want 0 after single pop", out_valid);
        end
    endtask

    task automatic test_saturation();
        step(2'b00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b0);
        end
        step(2'b00, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (dec_cnt_s !== 2'd3 || dec_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL sat_hold: got cnt2=%0d cnt8=%0d want cnt2=3 cnt8=5", dec_cnt_s, dec_cnt);
        end
        step(2'b10, 1'b1, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b1, 1'b1);
        n_tests++;
        if (dec_cnt_s !== 2'd0 || dec_cnt !== 8'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_clear: got cnt2=%0d cnt8=%0d v=%b want 0 0 0", dec_cnt_s, dec_cnt, out_valid);
        end
    endtask

    task automatic test_soak();
        for (int i = 0; i < 10000; i++) begin
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
            n_tests++;
            if (out_valid !== m_valid() || out_onehot !== m_head() || in_ready !== m_ready() ||
                dec_cnt !== 8'(m_cnt8) || dec_cnt_s !== 2'(m_cnt2)) begin
                n_fail++;
                if (n_fail < 20)
                    $display("FAIL soak_cyc%0d: got v=%b oh=%b rdy=%b cnt=%0d cnt2=%0d want v=%b oh=%b rdy=%b cnt=%0d cnt2=%0d",
                             i, out_valid, out_onehot, in_ready, dec_cnt, dec_cnt_s,
                             m_valid(), m_head(), m_ready(), m_cnt8, m_cnt2);
            end
            n_tests++;
            if ((out_valid === 1'b1 && $countones(out_onehot) != 1) ||
                (out_valid === 1'b0 && out_onehot !== 4'b0000)) begin
                n_fail++;
                if (n_fail < 20)
                    $display("FAIL soak_onehot%0d: got v=%b oh=%b want one-hot when valid else 0000",
                             i, out_valid, out_onehot);
            end
        end
    endtask

    initial begin
        test_reset();
        test_map_sweep();
        test_backpressure();
        test_simul_push_pop();
        test_saturation();
        test_soak();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
